// File: rtl/fu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fu_pkg
// Description : Shared definitions for the pipelined add/subtract unit.
//               Holds the chunk-partitioning helpers, the signed saturation
//               constant helpers and the mode-bit bundle carried down the
//               pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package fu_pkg;

    // Widest operand the saturation helpers can describe.
    localparam int c_max_width = 128;

    // Mode bits captured with each beat and carried to the final stage.
    typedef struct packed {
        logic sub;
        logic signed_mode;
        logic sat;
    } mode_t;

    // Bit position where chunk k starts. Chunks are ceil(width/stages) wide.
    // The start is pulled down where needed so that every later chunk still
    // gets at least one bit (e.g. 34 bits over 8 stages gives 5,5,5,5,5,5,3,1).
    // k == stages returns width, so chunk_lo(k+1) - chunk_lo(k) is always
    // the width of chunk k.
    function automatic int chunk_lo(input int width, input int stages, input int k);
        int chunk;
        int by_chunk;
        int by_room;
        chunk    = (width + stages - 1) / stages;
        by_chunk = k * chunk;
        by_room  = width - (stages - k);
        return (by_chunk < by_room) ? by_chunk : by_room;
    endfunction

    function automatic int chunk_width(input int width, input int stages, input int k);
        return chunk_lo(width, stages, k + 1) - chunk_lo(width, stages, k);
    endfunction

    // Largest positive two's-complement value of the given width: 0 1...1.
    function automatic logic [c_max_width-1:0] SAT_MAX_S(input int width);
        logic [c_max_width-1:0] r;
        r = '0;
        for (int i = 0; i < c_max_width; i++) begin
            r[i] = (i < width - 1);
        end
        return r;
    endfunction

    // Most negative two's-complement value of the given width: 1 0...0.
    function automatic logic [c_max_width-1:0] SAT_MIN_S(input int width);
        logic [c_max_width-1:0] r;
        r = '0;
        for (int i = 0; i < c_max_width; i++) begin
            r[i] = (i == width - 1);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fu_addsub_stage.sv
`default_nettype none
// ============================================================================
// Module      : fu_addsub_stage
// Description : One pipeline stage of the chunked adder. Adds bits
//               [LO +: CW] of the two operands plus the incoming carry,
//               merges that chunk into the partial result and registers the
//               whole beat when the stage is allowed to advance.
// Ports       : clk, rst      - clock, async active-high reset
//               load          - stage may advance this cycle
//               valid         - beat presented by the previous stage
//               a, b, sum     - operands (b already inverted for subtract)
//                               and partial result from the previous stage
//               cin, mode     - incoming carry and mode bundle
//               q_*           - registered beat handed to the next stage;
//                               q_c_msb is the carry into the MSB (only
//                               meaningful in the stage that owns the MSB)
// Revision    : 1.0 - initial release
// ============================================================================
module fu_addsub_stage
    import fu_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int LO    = 0,
    parameter int CW    = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    input  logic             cin,
    input  mode_t            mode,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    output logic [WIDTH-1:0] q_sum,
    output logic             q_carry,
    output mode_t            q_mode,
    output logic             q_a_msb,
    output logic             q_c_msb
);

    logic [CW:0]      w_chunk;
    logic [WIDTH-1:0] w_sum;
    logic             w_c_msb;

    always_comb begin
        w_chunk           = {1'b0, a[LO +: CW]} + {1'b0, b[LO +: CW]} + {{CW{1'b0}}, cin};
        w_sum             = sum;
        w_sum[LO +: CW]   = w_chunk[CW-1:0];
    end

    // sum = a ^ b ^ carry_in per bit, so the carry into the MSB falls out of
    // the MSB sum bit once the chunk holding it has been added.
    assign w_c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ w_sum[WIDTH-1];

    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    mode_t            r_mode;
    logic             r_c_msb;

    // Data registers only move with a real beat so the outputs of an idle
    // pipeline keep their last value instead of following the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_mode  <= '0;
            r_c_msb <= 1'b0;
        end else if (load) begin
            r_valid <= valid;
            if (valid) begin
                r_a     <= a;
                r_b     <= b;
                r_sum   <= w_sum;
                r_carry <= w_chunk[CW];
                r_mode  <= mode;
                r_c_msb <= w_c_msb;
            end
        end
    end

    assign q_valid = r_valid;
    assign q_a     = r_a;
    assign q_b     = r_b;
    assign q_sum   = r_sum;
    assign q_carry = r_carry;
    assign q_mode  = r_mode;
    assign q_a_msb = r_a[WIDTH-1];
    assign q_c_msb = r_c_msb;

endmodule
`default_nettype wire

// File: rtl/fu_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : fu_pipe_addsub
// Description : Pipelined WIDTH-bit adder/subtractor split into STAGES
//               ripple chunks, with signed/unsigned overflow detection,
//               optional saturation and valid/ready handshakes.
// Ports       : clk, rst                 - clock, async active-high reset
//               in_valid / in_ready      - operand handshake
//               din1, din2               - operands A and B
//               carry_in                 - carry into bit 0 (add only)
//               sub, signed_mode, sat    - operation and flag modes
//               out_valid / out_ready    - result handshake
//               dout                     - result, possibly saturated
//               carry_out                - raw carry out of the MSB
//               overflow                 - overflow for the selected mode
// Notes       : Requires WIDTH >= 4, 1 <= STAGES <= 8 and STAGES <= WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module fu_pipe_addsub
    import fu_pkg::*;
#(
    parameter int WIDTH  = 34,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             carry_in,
    input  logic             sub,
    input  logic             signed_mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_sat_max = WIDTH'(SAT_MAX_S(WIDTH));
    localparam logic [WIDTH-1:0] c_sat_min = WIDTH'(SAT_MIN_S(WIDTH));

    // Index 0 is the prepared input beat; index k+1 is the output of stage k.
    logic [STAGES:0]  st_valid;
    logic [STAGES:0]  st_carry;
    logic [WIDTH-1:0] st_a   [0:STAGES];
    logic [WIDTH-1:0] st_b   [0:STAGES];
    logic [WIDTH-1:0] st_sum [0:STAGES];
    mode_t            st_mode[0:STAGES];
    logic             st_a_msb[1:STAGES];
    logic             st_c_msb[1:STAGES];

    logic [STAGES-1:0] w_adv;

    // Operand prep: subtract is A + ~B + 1, so carry_in is dropped.
    assign st_valid[0] = in_valid;
    assign st_a[0]     = din1;
    assign st_b[0]     = sub ? ~din2 : din2;
    assign st_sum[0]   = '0;
    assign st_carry[0] = sub | carry_in;
    assign st_mode[0]  = {sub, signed_mode, sat};

    // Stage k may load when it or any stage after it holds a bubble, or when
    // the output is being drained. Written as a backward OR-scan so there is
    // no combinational chain through a single signal.
    always_comb begin
        logic acc;
        acc   = out_ready;
        w_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc      = acc | ~st_valid[k+1];
            w_adv[k] = acc;
        end
    end

    assign in_ready = w_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_lo = chunk_lo(WIDTH, STAGES, k);
        localparam int c_cw = chunk_width(WIDTH, STAGES, k);

        fu_addsub_stage #(
            .WIDTH (WIDTH),
            .LO    (c_lo),
            .CW    (c_cw)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (w_adv[k]),
            .valid   (st_valid[k]),
            .a       (st_a[k]),
            .b       (st_b[k]),
            .sum     (st_sum[k]),
            .cin     (st_carry[k]),
            .mode    (st_mode[k]),
            .q_valid (st_valid[k+1]),
            .q_a     (st_a[k+1]),
            .q_b     (st_b[k+1]),
            .q_sum   (st_sum[k+1]),
            .q_carry (st_carry[k+1]),
            .q_mode  (st_mode[k+1]),
            .q_a_msb (st_a_msb[k+1]),
            .q_c_msb (st_c_msb[k+1])
        );
    end

    mode_t            w_fin_mode;
    logic [WIDTH-1:0] w_raw;
    logic             w_ovf_s;
    logic             w_ovf_u;

    assign out_valid  = st_valid[STAGES];
    assign carry_out  = st_carry[STAGES];
    assign w_raw      = st_sum[STAGES];
    assign w_fin_mode = st_mode[STAGES];

    // Unsigned subtract overflows on borrow, i.e. when no carry comes out.
    assign w_ovf_s  = carry_out ^ st_c_msb[STAGES];
    assign w_ovf_u  = w_fin_mode.sub ? ~carry_out : carry_out;
    assign overflow = w_fin_mode.signed_mode ? w_ovf_s : w_ovf_u;

    // Signed overflow can only happen when the true result has the sign of
    // A, which picks the clamp direction.
    always_comb begin
        dout = w_raw;
        if (w_fin_mode.sat && overflow) begin
            if (w_fin_mode.signed_mode) begin
                dout = st_a_msb[STAGES] ? c_sat_min : c_sat_max;
            end else begin
                dout = w_fin_mode.sub ? '0 : '1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fu_pipe_addsub.md
Name: fu_pipe_addsub

Overview:
- Parametrised, pipelined successor to the fixed-width combinational adder in the MIPS datapath.
- Adds or subtracts two WIDTH-bit operands split into STAGES ripple chunks, one chunk per register stage.
- Selectable signed or unsigned overflow detection, plus an optional saturation mode.
- Valid/ready handshake at both ends; feeds the multi-cycle execution units (MAC, address generation) where a single-cycle 34-bit carry chain breaks timing.

Parameters:
- WIDTH, 34: operand and result width in bits; minimum 4.
- STAGES, 2: pipeline depth, 1..8. CHUNK = ceil(WIDTH/STAGES). The last chunk takes the remainder and is at least 1 bit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- din1  in  WIDTH  operand A.
- din2  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0; used for add only.
- sub  in  1  1 = A-B, 0 = A+B+carry_in.
- signed_mode  in  1  1 = two's-complement overflow/saturation, 0 = unsigned.
- sat  in  1  1 = clamp result on overflow.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- dout  out  WIDTH  sum/difference, possibly saturated.
- carry_out  out  1  raw carry out of the MSB, unaffected by saturation.
- overflow  out  1  overflow flag for the selected mode.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0. out_valid=0, dout=0, carry_out=0, overflow=0. in_ready=1 from the first edge after release.
- Reset mid-operation flushes all in-flight beats; none are emitted.
- Operand prep at accept:
  - B' = sub ? ~din2 : din2.
  - c0 = sub ? 1 : carry_in. carry_in is ignored when sub=1.
- Stage k (0-based) adds chunk k of A and B' with the carry from stage k-1 (c0 for k=0).
- Each stage registers:
  - its result chunk and carry;
  - the unprocessed upper operand chunks;
  - the mode bits sub, signed_mode, sat;
  - A[MSB] and B'[MSB].
- The last stage also registers the carry into the MSB, c_msb.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when there is no stall (STAGES=1: registered, valid the cycle after accept).
- Stall rules:
  - Stage k advances when stage k is empty or stage k+1 advances; the last stage advances when !out_valid or out_ready.
  - in_ready = stage-0 advance condition.
  - A full pipeline with out_ready=0 holds every register; no beat is lost or duplicated.
  - Full throughput is one beat per cycle with out_ready held high.
- Flags at final stage:
  - carry_out = final carry.
  - Signed overflow: ovf_s = carry_out ^ c_msb.
  - Unsigned overflow: ovf_u = sub ? ~carry_out : carry_out (borrow on subtract).
  - overflow = signed_mode ? ovf_s : ovf_u.
- Saturation, applied when sat=1 and overflow=1:
  - signed, A[MSB]=0 -> 0 followed by WIDTH-1 ones (max positive).
  - signed, A[MSB]=1 -> 1 followed by WIDTH-1 zeros (min negative).
  - unsigned add -> all ones.
  - unsigned sub -> all zeros.
  - sat=0 leaves the raw result; overflow is reported either way.
- dout, carry_out and overflow hold stable while out_valid=1 and out_ready=0.
- Simultaneous accept on input and drain on output in the same cycle is legal with a full pipeline.

Decomposition:
- Shared package fu_pkg holds:
  - function chunk_width(WIDTH, STAGES, k);
  - saturation constant helpers SAT_MAX_S / SAT_MIN_S as WIDTH-parametrised functions;
  - the mode-bit bundle layout {sub, signed_mode, sat}.
- One sub-module: fu_addsub_stage. It holds one chunk adder plus the valid/hold register, instantiated STAGES times in a generate loop. Flag and saturation logic stays at the top level.

Test Plan (WIDTH=34, STAGES=2 unless stated):
- Reset then one add, din1=0x0_0001_FFFF, din2=0x1, carry_in=0 -> out_valid 2 cycles after accept; dout=0x0_0002_0000, carry_out=0, overflow=0. Exercises carry across the 17-bit chunk boundary.
- Signed add with sat, 0x1_FFFF_FFFF + 0x1 -> raw 0x2_0000_0000, overflow=1, dout=0x1_FFFF_FFFF. Repeat with sat=0 -> dout=0x2_0000_0000.
- Unsigned sub, 0x5 - 0x7, sat=1 -> carry_out=0, overflow=1, dout=0. With sat=0 -> dout=0x3_FFFF_FFFE.
- Back-to-back 8 beats with out_ready toggling 1,0,0,1,... -> results in order, none dropped or duplicated, in_ready low only while full and stalled. Compare against a reference model.
- Assert rst while 2 beats are in flight -> out_valid drops immediately; no stale beat after release; the next beat computes correctly.
- Sweep STAGES=1,3,8 and WIDTH=32,64 with random operands and modes -> latency equals STAGES cycles; results match a reference model.
